// File: rtl/spi_reg_ctrl.sv
// Byte-level command controller behind a mode-0 SPI slave: decodes a command byte,
// then streams auto-incrementing register writes or reads, with sticky error flags.
module spi_reg_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    input  logic                  i_SPI_CS_n,
    output logic [ADDR_WIDTH-1:0] o_Reg_Addr,
    output logic [7:0]            o_Reg_WData,
    output logic                  o_Reg_Wr,
    output logic                  o_Reg_Rd,
    input  logic [7:0]            i_Reg_RData,
    input  logic                  i_Reg_Ack,
    input  logic                  i_Err_Clr,
    output logic                  o_Busy,
    output logic                  o_Txn_Done,
    output logic [7:0]            o_Byte_Count,
    output logic                  o_Err_Timeout,
    output logic                  o_Err_Overrun
);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, WR_DATA, WR_WAIT, RD_REQ, RD_WAIT, RD_NEXT
    } state_t;

    state_t                  state_q, state_d;
    logic                    cs_meta_q, cs_sync_q, cs_prev_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    wr_q, wr_d, rd_q, rd_d;
    logic                    tx_dv_q, tx_dv_d;
    logic [7:0]              tx_byte_q, tx_byte_d;
    logic                    done_q, done_d;
    logic [7:0]              count_q, count_d;
    logic                    pend_q, pend_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    err_t_q, err_t_d, err_o_q, err_o_d;
    logic                    frame_start, frame_end, tmo_hit;

    assign frame_start = cs_prev_q & ~cs_sync_q;
    assign frame_end   = ~cs_prev_q & cs_sync_q;
    assign tmo_hit     = (tmo_q == TMO_LAST);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_prev_q  <= 1'b1;
            state_q    <= IDLE;
            addr_q     <= '0;
            reg_addr_q <= '0;
            wdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            done_q     <= 1'b0;
            count_q    <= 8'h00;
            pend_q     <= 1'b1;
            tmo_q      <= '0;
            err_t_q    <= 1'b0;
            err_o_q    <= 1'b0;
        end else begin
            cs_meta_q  <= i_SPI_CS_n;
            cs_sync_q  <= cs_meta_q;
            cs_prev_q  <= cs_sync_q;
            state_q    <= state_d;
            addr_q     <= addr_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            done_q     <= done_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            tmo_q      <= tmo_d;
            err_t_q    <= err_t_d;
            err_o_q    <= err_o_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        done_d     = 1'b0;
        count_d    = count_q;
        pend_d     = pend_q;
        tmo_d      = tmo_q + TW'(1);
        err_t_d    = err_t_q & ~i_Err_Clr;
        err_o_d    = err_o_q & ~i_Err_Clr;

        if (i_RX_DV && (state_q != IDLE || frame_end) && count_q != 8'hFF)
            count_d = count_q + 8'd1;

        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = STATUS_BYTE;
                    pend_d    = 1'b0;
                end
            end
            CMD: begin
                if (i_RX_DV) begin
                    addr_d  = i_RX_Byte[ADDR_WIDTH-1:0];
                    state_d = i_RX_Byte[7] ? WR_DATA : RD_REQ;
                end
            end
            WR_DATA: begin
                if (i_RX_DV) begin
                    wr_d       = 1'b1;
                    wdata_d    = i_RX_Byte;
                    reg_addr_d = addr_q;
                    tmo_d      = '0;
                    state_d    = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (i_RX_DV) err_o_d = 1'b1;
                if (i_Reg_Ack || tmo_hit) begin
                    if (!i_Reg_Ack) err_t_d = 1'b1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = WR_DATA;
                end
            end
            RD_REQ: begin
                if (i_RX_DV) err_o_d = 1'b1;
                rd_d       = 1'b1;
                reg_addr_d = addr_q;
                tmo_d      = '0;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                if (i_RX_DV) err_o_d = 1'b1;
                if (i_Reg_Ack || tmo_hit) begin
                    tx_dv_d = 1'b1;
                    if (i_Reg_Ack) begin
                        tx_byte_d = i_Reg_RData;
                    end else begin
                        tx_byte_d = 8'hFF;
                        err_t_d   = 1'b1;
                    end
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = RD_NEXT;
                end
            end
            RD_NEXT: begin
                if (i_RX_DV) state_d = RD_REQ;
            end
            default: state_d = IDLE;
        endcase

        // Frame boundaries override whatever the FSM decided this cycle.
        if (frame_start) begin
            state_d = CMD;
            count_d = 8'h00;
            if (pend_q) begin
                tx_dv_d   = 1'b1;
                tx_byte_d = STATUS_BYTE;
                pend_d    = 1'b0;
            end
        end else if (frame_end) begin
            // A write byte landing on the boundary still goes out; a read reply or new read does not.
            state_d   = IDLE;
            done_d    = 1'b1;
            pend_d    = 1'b1;
            rd_d      = 1'b0;
            tx_dv_d   = 1'b0;
            tx_byte_d = tx_byte_q;
        end
    end

    assign o_TX_DV       = tx_dv_q;
    assign o_TX_Byte     = tx_byte_q;
    assign o_Reg_Addr    = reg_addr_q;
    assign o_Reg_WData   = wdata_q;
    assign o_Reg_Wr      = wr_q;
    assign o_Reg_Rd      = rd_q;
    assign o_Busy        = (state_q != IDLE);
    assign o_Txn_Done    = done_q;
    assign o_Byte_Count  = count_q;
    assign o_Err_Timeout = err_t_q;
    assign o_Err_Overrun = err_o_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus queues expected bus/TX/done events and
// status probes; a negedge monitor pops and compares them as the DUT produces outputs.
module tb_spi_reg_ctrl;
    localparam int AW = 7;
    localparam int K_WR = 0, K_RD = 1, K_TX = 2, K_DONE = 3;

    typedef struct {
        int    kind;
        int    a;
        int    b;
        string nm;
    } ev_t;

    typedef struct {
        bit    is_end;
        int    busy;
        int    err_t;
        int    err_o;
        int    count;
        int    txb;
        string nm;
    } probe_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          cs_n;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_wr, reg_rd;
    logic [7:0]    reg_rdata;
    logic          reg_ack;
    logic          err_clr;
    logic          busy, txn_done, err_timeout, err_overrun;
    logic [7:0]    byte_count;

    ev_t    exp_q[$];
    probe_t probe_q[$];
    int     errors = 0;
    int     checks = 0;
    int     ack_delay = 3;
    int     late_ack_req = 0;

    always #5 clk = ~clk;

    spi_reg_ctrl #(.ADDR_WIDTH(AW), .STATUS_BYTE(8'hA5), .ACK_TIMEOUT(16)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
        .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .i_SPI_CS_n(cs_n),
        .o_Reg_Addr(reg_addr), .o_Reg_WData(reg_wdata), .o_Reg_Wr(reg_wr), .o_Reg_Rd(reg_rd),
        .i_Reg_RData(reg_rdata), .i_Reg_Ack(reg_ack), .i_Err_Clr(err_clr),
        .o_Busy(busy), .o_Txn_Done(txn_done), .o_Byte_Count(byte_count),
        .o_Err_Timeout(err_timeout), .o_Err_Overrun(err_overrun)
    );

    // Register-bus responder: acks each strobe after ack_delay cycles (0 = never), plus on-demand late acks.
    initial begin
        int cnt;
        int seen;
        logic [7:0] data;
        cnt = 0; seen = 0; data = 8'h00;
        reg_ack = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            @(negedge clk);
            reg_ack = 1'b0;
            if (late_ack_req != seen) begin
                seen = late_ack_req;
                reg_ack = 1'b1;
                reg_rdata = 8'h77;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    reg_ack = 1'b1;
                    reg_rdata = data;
                end
            end
            if ((reg_wr || reg_rd) && ack_delay > 0) begin
                cnt = ack_delay;
                data = {1'b0, reg_addr} + 8'h40;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic got(input int k, input int a, input int b);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d a=%0h b=%0h, required no event", k, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b) begin
                errors++;
                $display("FAIL %s: got kind=%0d a=%0h b=%0h, required kind=%0d a=%0h b=%0h",
                         e.nm, k, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    // Monitor
    initial begin
        probe_t p;
        forever begin
            @(negedge clk);
            if (reg_wr)   got(K_WR, int'(reg_addr), int'(reg_wdata));
            if (reg_rd)   got(K_RD, int'(reg_addr), 0);
            if (tx_dv)    got(K_TX, 0, int'(tx_byte));
            if (txn_done) got(K_DONE, int'(byte_count), 0);
            if (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                if (p.is_end) begin
                    chk("events_outstanding", exp_q.size(), 0);
                end else begin
                    chk({p.nm, ".busy"},   int'(busy), p.busy);
                    chk({p.nm, ".err_t"},  int'(err_timeout), p.err_t);
                    chk({p.nm, ".err_o"},  int'(err_overrun), p.err_o);
                    chk({p.nm, ".count"},  int'(byte_count), p.count);
                    chk({p.nm, ".tx_byte"}, int'(tx_byte), p.txb);
                end
            end
        end
    end

    task automatic expect_ev(input int k, input int a, input int b, input string nm);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic probe(input string nm, input int bsy, input int et, input int eo,
                         input int cnt, input int txb);
        probe_t p;
        p.is_end = 1'b0; p.busy = bsy; p.err_t = et; p.err_o = eo;
        p.count = cnt; p.txb = txb; p.nm = nm;
        probe_q.push_back(p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        idle(5);
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        idle(8);
    endtask

    initial begin
        probe_t pe;
        rst = 1'b1; cs_n = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; err_clr = 1'b0;
        idle(3);
        probe("reset", 0, 0, 0, 0, 8'h00);
        expect_ev(K_TX, 0, 8'hA5, "preload_after_reset");
        idle(1);
        rst = 1'b0;
        idle(4);
        probe("idle_after_reset", 0, 0, 0, 0, 8'hA5);
        idle(1);

        // Write frame: 85 11 22
        ack_delay = 3;
        expect_ev(K_WR, 5, 8'h11, "wr_addr5");
        expect_ev(K_WR, 6, 8'h22, "wr_addr6");
        expect_ev(K_DONE, 3, 0, "wr_done");
        expect_ev(K_TX, 0, 8'hA5, "wr_preload");
        frame_begin();
        probe("wr_frame_start", 1, 0, 0, 0, 8'hA5);
        send(8'h85); idle(10);
        send(8'h11); idle(10);
        send(8'h22); idle(10);
        frame_end();
        probe("wr_frame_idle", 0, 0, 0, 3, 8'hA5);
        idle(1);

        // Read frame with address wrap: 7F, dummy, dummy
        expect_ev(K_RD, 8'h7F, 0, "rd_addr7f");
        expect_ev(K_TX, 0, 8'hBF, "rd_data_bf");
        expect_ev(K_RD, 8'h00, 0, "rd_addr00_wrap");
        expect_ev(K_TX, 0, 8'h40, "rd_data_40");
        expect_ev(K_RD, 8'h01, 0, "rd_addr01");
        expect_ev(K_TX, 0, 8'h41, "rd_data_41");
        expect_ev(K_DONE, 3, 0, "rd_done");
        expect_ev(K_TX, 0, 8'hA5, "rd_preload");
        frame_begin();
        send(8'h7F); idle(10);
        send(8'h00); idle(10);
        send(8'h00); idle(10);
        frame_end();
        probe("rd_frame_idle", 0, 0, 0, 3, 8'hA5);
        idle(1);

        // Read with no ack -> timeout
        ack_delay = 0;
        expect_ev(K_RD, 8'h03, 0, "tmo_rd");
        expect_ev(K_TX, 0, 8'hFF, "tmo_data_ff");
        expect_ev(K_DONE, 1, 0, "tmo_done");
        expect_ev(K_TX, 0, 8'hA5, "tmo_preload");
        frame_begin();
        send(8'h03);
        idle(25);
        probe("tmo_mid", 1, 1, 0, 1, 8'hFF);
        idle(1);
        frame_end();
        probe("tmo_after_frame", 0, 1, 0, 1, 8'hA5);
        idle(1);

        // Overrun: second write byte arrives during WR_WAIT
        ack_delay = 3;
        expect_ev(K_WR, 8'h10, 8'h33, "ovr_wr");
        expect_ev(K_DONE, 3, 0, "ovr_done");
        expect_ev(K_TX, 0, 8'hA5, "ovr_preload");
        frame_begin();
        probe("tmo_sticky_next_frame", 1, 1, 0, 0, 8'hA5);
        send(8'h90); idle(10);
        send(8'h33);
        send(8'h44);
        idle(10);
        frame_end();
        probe("ovr_after_frame", 0, 1, 1, 3, 8'hA5);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        probe("err_cleared", 0, 0, 0, 3, 8'hA5);
        idle(1);

        // CS rise during RD_WAIT, then a late ack
        ack_delay = 0;
        expect_ev(K_RD, 8'h05, 0, "abort_rd");
        expect_ev(K_DONE, 1, 0, "abort_done");
        expect_ev(K_TX, 0, 8'hA5, "abort_preload");
        frame_begin();
        send(8'h05);
        idle(3);
        cs_n = 1'b1;
        idle(6);
        probe("abort_idle", 0, 0, 0, 1, 8'hA5);
        idle(1);
        late_ack_req++;
        idle(6);
        probe("abort_late_ack", 0, 0, 0, 1, 8'hA5);
        idle(2);

        pe.is_end = 1'b1; pe.busy = 0; pe.err_t = 0; pe.err_o = 0;
        pe.count = 0; pe.txb = 0; pe.nm = "end";
        probe_q.push_back(pe);
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Byte-level command controller behind the mode-0 SPI slave.
- Parses each CS_n-framed transaction into a command byte followed by data bytes.
- Issues read and write strobes to a simple register bus, with auto-incrementing addresses.
- Loads the slave's TX byte so read data reaches MISO on the following byte; tracks framing and timing errors.

Parameters:
- ADDR_WIDTH, 7, register address width (1..7); addresses wrap modulo 2^ADDR_WIDTH.
- STATUS_BYTE, 8'hA5, byte preloaded for MISO during the command byte.
- ACK_TIMEOUT, 16, i_Clk cycles to wait for i_Reg_Ack before flagging a timeout (≥2).

Ports:
- i_Clk  in  1  system clock; same clock as the slave's i_Clk.
- i_Rst  in  1  asynchronous, active-high reset.
- i_RX_DV  in  1  one-cycle pulse from the slave: received byte valid.
- i_RX_Byte  in  8  received byte.
- o_TX_DV  out  1  one-cycle pulse: slave registers o_TX_Byte.
- o_TX_Byte  out  8  next byte to serialise on MISO.
- i_SPI_CS_n  in  1  raw chip select, asynchronous; synchronised internally.
- o_Reg_Addr  out  ADDR_WIDTH  register address.
- o_Reg_WData  out  8  write data.
- o_Reg_Wr  out  1  one-cycle write strobe.
- o_Reg_Rd  out  1  one-cycle read strobe.
- i_Reg_RData  in  8  read data; valid when i_Reg_Ack=1.
- i_Reg_Ack  in  1  one-cycle completion for the outstanding Wr or Rd.
- i_Err_Clr  in  1  clears the sticky error flags.
- o_Busy  out  1  high when state != IDLE.
- o_Txn_Done  out  1  one-cycle pulse at frame end.
- o_Byte_Count  out  8  bytes received in the current or last frame.
- o_Err_Timeout  out  1  sticky: an ack did not arrive within ACK_TIMEOUT cycles.
- o_Err_Overrun  out  1  sticky: a byte arrived while the controller was waiting on the bus.

Behaviour:
- Reset (async, i_Rst=1):
  - state=IDLE; all outputs 0; o_TX_Byte=8'h00; address=0.
  - The preload-pending flag is set.
- CS synchronisation: i_SPI_CS_n passes through a 2-FF synchroniser.
  - Falling edge of the synchronised value = frame start.
  - Rising edge = frame end.
- Preload: in IDLE with preload pending, pulse o_TX_DV for 1 cycle with o_TX_Byte=STATUS_BYTE, then clear pending. Pending is re-set at every frame end.
- Frame start, from any state:
  - state→CMD; o_Byte_Count=0.
  - If preload is still pending, it is issued in the same cycle.
- Byte counting: every i_RX_DV inside a frame increments o_Byte_Count, saturating at 255. The count holds after frame end.
- FSM, on a single i_Clk domain:
  - CMD: on i_RX_DV, latch dir=byte[7] (1=write) and addr=byte[ADDR_WIDTH-1:0]. dir=1 → WR_DATA; dir=0 → RD_REQ.
  - WR_DATA: on i_RX_DV, o_Reg_Wr=1 for 1 cycle with o_Reg_WData=byte and o_Reg_Addr=addr, then → WR_WAIT. No o_TX_DV is issued during writes (MISO repeats the last loaded byte).
  - WR_WAIT: on i_Reg_Ack or timeout, addr←addr+1 (wrap) → WR_DATA.
  - RD_REQ: o_Reg_Rd=1 for 1 cycle with o_Reg_Addr=addr → RD_WAIT.
  - RD_WAIT: on i_Reg_Ack, o_TX_DV=1 with o_TX_Byte=i_Reg_RData, then addr+1 → RD_NEXT. On timeout, set o_Err_Timeout and load o_TX_Byte=8'hFF instead; otherwise identical.
  - RD_NEXT: on i_RX_DV (master's dummy byte, content ignored) → RD_REQ.
- Timeout counter: reset on entry to WR_WAIT/RD_WAIT. Timeout fires when the count reaches ACK_TIMEOUT-1 with no ack.
- Bus-signal timing: o_Reg_Addr and o_Reg_WData hold their value until the next strobe. i_Reg_Ack is ignored outside WR_WAIT/RD_WAIT.
- Overrun: i_RX_DV in WR_WAIT, RD_REQ or RD_WAIT sets o_Err_Overrun.
  - The byte is counted but not written.
  - The FSM continues unchanged.
- Frame end, from any state:
  - state→IDLE; o_Txn_Done=1 for 1 cycle; an outstanding ack is abandoned.
  - Already-issued strobes are not retracted.
  - If i_RX_DV coincides with frame end, the byte is counted and, if in WR_DATA, its write strobe is still issued. Next state is IDLE regardless.
- Sticky errors: i_Err_Clr clears both flags. A new error in the same cycle wins (the flag stays 1).
- Reset mid-frame: immediate return to reset values. The synchroniser resets to 1 (CS inactive).

Test Plan:
- Reset, then release → o_TX_DV pulses once with 8'hA5 within 2 cycles; o_Busy=0 and all flags 0.
- Frame with bytes 8'h85, 8'h11, 8'h22, ack after 3 cycles each → Wr strobes at addr 5 (data 11) and addr 6 (data 22). o_Byte_Count=3 and o_Txn_Done pulses at CS rise.
- Frame with bytes 8'h7F then 2 dummy bytes, ADDR_WIDTH=7, RData=addr+8'h40 → Rd at 7F then at 00 (wrap). o_TX_Byte sequence is 8'hBF, 8'h40.
- Read with no ack → o_TX_Byte=8'hFF after 16 cycles and o_Err_Timeout=1. It stays 1 across frames until an i_Err_Clr pulse.
- Write byte arriving during WR_WAIT → o_Err_Overrun=1, no extra Wr strobe, count incremented.
- CS rise during RD_WAIT, then a late ack → state IDLE, no o_TX_DV from the ack, preload re-issued with 8'hA5.
